alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 41 ++++
 rtl/alu_seq_if.sv | 23 ++
 rtl/alu_seq_wdog.sv | 27 ++
 rtl/alu_seq.sv | 145 ++++++++++++++
 tb/tb_alu_seq.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq sequencer: opcodes, FSM states,
// flag bit positions and the ALU control codes that programs use.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_LDI  = 4'h0,
    OP_LDB  = 4'h1,
    OP_ALU  = 4'h2,
    OP_JMP  = 4'h3,
    OP_JZ   = 4'h4,
    OP_JC   = 4'h5,
    OP_JN   = 4'h6,
    OP_JV   = 4'h7,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    DONE
  } state_t;

  localparam int unsigned FLG_V = 3;
  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_C = 0;

  localparam logic [3:0] PASS = 4'b0000;
  localparam logic [3:0] ADD  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b0101;

  // Count value seen during EXEC of the 255th instruction of a run.
  localparam logic [7:0] WDOG_TC = 8'd254;

  function automatic logic [3:0] pc_inc(input logic [3:0] pc);
    return pc + 4'd1;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Program-memory and ALU bus of the sequencer; master = sequencer side,
// slave = ROM/ALU side.
interface alu_seq_if;

  logic [3:0] instr_addr;
  logic [7:0] instr_data;
  logic [3:0] alu_ctrl;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_f;
  logic [3:0] alu_flags;

  modport master (
    output instr_addr, alu_ctrl, alu_a, alu_b,
    input  instr_data, alu_f, alu_flags
  );

  modport slave (
    input  instr_addr, alu_ctrl, alu_a, alu_b,
    output instr_data, alu_f, alu_flags
  );

endinterface

// File: rtl/alu_seq_wdog.sv
// Instruction watchdog for alu_seq: counts EXEC cycles since the last accepted
// start and flags the terminal count. Only built under ALU_SEQ_WDOG_EN.
module alu_seq_wdog
  import alu_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_tc = (r_cnt == WDOG_TC);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer driving a 4-bit ALU from a 16-word
// registered program ROM. Optional watchdog abort enabled by ALU_SEQ_WDOG_EN.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  alu_seq_if.master        bus,
  output logic [3:0]       acc,
  output logic [3:0]       status,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t     r_state;
  logic [3:0] r_pc;
  logic [7:0] r_ir;
  logic [3:0] r_acc;
  logic [3:0] r_breg;
  logic [3:0] r_status;
  logic [3:0] r_alu_ctrl;
  logic       r_busy;
  logic       r_done;
  logic       r_err;

  opcode_t    w_op;
  logic [3:0] w_imm;
  logic       w_take;
  logic [3:0] w_pc_next;
  logic       w_start_acc;
  logic       w_exec;
  logic       w_wdog_tc;
  logic       w_wdog_trip;

  assign w_op        = opcode_t'(r_ir[7:4]);
  assign w_imm       = r_ir[3:0];
  assign w_start_acc = (r_state == IDLE) && start;
  assign w_exec      = (r_state == EXEC);

  always_comb begin
    w_take = 1'b0;
    case (w_op)
      OP_JMP:  w_take = 1'b1;
      OP_JZ:   w_take = r_status[FLG_Z];
      OP_JC:   w_take = r_status[FLG_C];
      OP_JN:   w_take = r_status[FLG_N];
      OP_JV:   w_take = r_status[FLG_V];
      default: w_take = 1'b0;
    endcase
  end

  assign w_pc_next = w_take ? w_imm : pc_inc(r_pc);

`ifdef ALU_SEQ_WDOG_EN
  alu_seq_wdog u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_acc),
    .i_inc (w_exec),
    .o_tc  (w_wdog_tc)
  );
`else
  assign w_wdog_tc = 1'b0;
`endif

  assign w_wdog_trip = w_exec && w_wdog_tc && (w_op != OP_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_acc      <= '0;
      r_breg     <= '0;
      r_status   <= '0;
      r_alu_ctrl <= PASS;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= FETCH;
            r_pc    <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        FETCH: r_state <= DECODE;
        DECODE: begin
          r_ir    <= bus.instr_data;
          r_state <= EXEC;
          // alu_ctrl is registered, so it is set up from the ROM word here to be valid throughout EXEC
          r_alu_ctrl <= (bus.instr_data[7:4] == OP_ALU) ? bus.instr_data[3:0] : PASS;
        end
        EXEC: begin
          r_alu_ctrl <= PASS;
          case (w_op)
            OP_LDI: r_acc <= w_imm;
            OP_LDB: r_breg <= w_imm;
            OP_ALU: begin
              r_acc    <= bus.alu_f;
              r_status <= bus.alu_flags;
            end
            default: ;
          endcase
          if (w_op == OP_HALT) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_pc <= w_pc_next;
            if (w_wdog_trip) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state <= FETCH;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.instr_addr = r_pc;
  assign bus.alu_ctrl   = r_alu_ctrl;
  assign bus.alu_a      = r_acc;
  assign bus.alu_b      = r_breg;

  assign acc    = r_acc;
  assign status = r_status;
  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a registered ROM and a 4-bit ALU model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] acc;
  logic [3:0] status;
  logic       busy;
  logic       done;
  logic       err;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [7:0]  rom [16];
  int unsigned fa[$];
  logic [3:0]  ctl_tr [64];
  int          dc;

  alu_seq_if bus ();

  alu_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bus    (bus),
    .acc    (acc),
    .status (status),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.instr_data <= rom[bus.instr_addr];

  // ALU model: C is carry for ADD and borrow for SUB; flags {V,N,Z,C}
  logic [4:0] s;
  logic       v;
  always_comb begin
    s = {1'b0, bus.alu_a};
    v = 1'b0;
    case (bus.alu_ctrl)
      ADD: begin
        s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        v = (bus.alu_a[3] == bus.alu_b[3]) && (s[3] != bus.alu_a[3]);
      end
      SUB: begin
        s = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
        v = (bus.alu_a[3] != bus.alu_b[3]) && (s[3] != bus.alu_a[3]);
      end
      default: ;
    endcase
    bus.alu_f     = s[3:0];
    bus.alu_flags = {v, s[3], (s[3:0] == 4'h0), s[4]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] w);
    for (int i = 0; i < 16; i++) rom[i] = w;
  endtask

  task automatic run(input int max_cyc, output int dcyc);
    fa.delete();
    dcyc = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (c < 64) ctl_tr[c] = bus.alu_ctrl;
      if (done) begin
        dcyc = c;
        break;
      end
      if (c % 3 == 0) fa.push_back(32'(bus.instr_addr));
      @(negedge clk);
    end
  endtask

  task automatic check_fa(input string tag, input int unsigned a0, a1, a2, a3, a4);
    int unsigned e [5];
    e = '{a0, a1, a2, a3, a4};
    check({tag, "_len"}, fa.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_addr%0d", tag, i), (fa.size() > i) ? fa[i] : 32'hFFFF, e[i]);
  endtask

  initial begin
    int seen_done;
    int wd_cyc;
    logic wd_err;

    fill(8'hF0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_acc", acc, 0);
    check("rst_status", status, 0);
    check("rst_addr", bus.instr_addr, 0);
    check("rst_ctrl", bus.alu_ctrl, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // LDI 5, LDB 3, ADD, HALT: 5+3 = 8 overflows signed -> V,N
    fill(8'hF0);
    rom[0] = 8'h05; rom[1] = 8'h13; rom[2] = 8'h22; rom[3] = 8'hF0;
    run(100, dc);
    check("p1_done_cyc", dc, 12);
    check("p1_busy_in_done", busy, 1);
    check("p1_acc", acc, 8);
    check("p1_status", status, 4'b1100);
    check("p1_ctrl_decode", ctl_tr[7], 0);
    check("p1_ctrl_exec", ctl_tr[8], ADD);
    check("p1_ctrl_after", ctl_tr[9], 0);
    @(negedge clk);
    check("p1_busy_after", busy, 0);
    check("p1_done_after", done, 0);

    // LDI 7, LDB 1, ADD, JN 10, HALT@10
    fill(8'hF0);
    rom[0] = 8'h07; rom[1] = 8'h11; rom[2] = 8'h22; rom[3] = 8'h6A; rom[4] = 8'h00;
    run(100, dc);
    check("p2_done_cyc", dc, 15);
    check("p2_acc", acc, 8);
    check("p2_status", status, 4'b1100);
    check_fa("p2", 0, 1, 2, 3, 10);
    @(negedge clk);

    // Async reset in EXEC of the ALU instruction of program 1
    fill(8'hF0);
    rom[0] = 8'h05; rom[1] = 8'h13; rom[2] = 8'h22; rom[3] = 8'hF0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (8) @(negedge clk);
    check("mr_ctrl_pre", bus.alu_ctrl, ADD);
    check("mr_acc_pre", acc, 5);
    #2 rst_n = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_acc", acc, 0);
    check("mr_status", status, 0);
    check("mr_ctrl", bus.alu_ctrl, 0);
    check("mr_addr", bus.instr_addr, 0);
    check("mr_done", done, 0);
    @(negedge clk) rst_n = 1'b1;
    seen_done = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    check("mr_quiet", seen_done, 0);

    // LDI 3, LDB 3, SUB, JZ 7 -> taken
    fill(8'hF0);
    rom[0] = 8'h03; rom[1] = 8'h13; rom[2] = 8'h25; rom[3] = 8'h47;
    run(100, dc);
    check("p3_done_cyc", dc, 15);
    check("p3_acc", acc, 0);
    check("p3_status", status, 4'b0010);
    check_fa("p3", 0, 1, 2, 3, 7);
    @(negedge clk);

    // Same with LDI 4 -> not taken, falls to 4
    rom[0] = 8'h04;
    run(100, dc);
    check("p3b_acc", acc, 1);
    check("p3b_status", status, 4'b0000);
    check_fa("p3b", 0, 1, 2, 3, 4);
    @(negedge clk);

    // All NOPs: PC wraps; start pulse while busy must be ignored
    fill(8'h80);
    fa.delete();
    wd_cyc = -1;
    wd_err = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 780; c++) begin
      if (c % 3 == 0 && busy) fa.push_back(32'(bus.instr_addr));
      if (c == 20) start = 1'b1;
      if (c == 21) start = 1'b0;
      if (done && wd_cyc < 0) begin
        wd_cyc = c;
        wd_err = err;
      end
      @(negedge clk);
    end
    check("nop_start_ignored", (fa.size() > 7) ? fa[7] : 32'hFFFF, 7);
    check("nop_addr15", (fa.size() > 15) ? fa[15] : 32'hFFFF, 15);
    check("nop_wrap0", (fa.size() > 16) ? fa[16] : 32'hFFFF, 0);
    check("nop_wrap1", (fa.size() > 17) ? fa[17] : 32'hFFFF, 1);
`ifdef ALU_SEQ_WDOG_EN
    check("wdog_done_cyc", wd_cyc, 765);
    check("wdog_err", wd_err, 1);
    check("wdog_idle", busy, 0);
`else
    check("nowd_no_done", wd_cyc, 32'hFFFFFFFF);
    check("nowd_busy", busy, 1);
    check("nowd_err", err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
